// File: rtl/core_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module : core_wb_bridge
// Brief  : Core native req/resp port to pipelined Wishbone master with line
//          fetches, lane steering, optional registered response and errors.
// Rev    : 1.0  initial release
// ============================================================================

module core_wb_bridge #(
    parameter int LINE_WORDS     = 4,
    parameter int REG_RESP       = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic                      cmd_i,
    input  logic [1:0]                width_i,
    input  logic [31:0]               addr_i,
    input  logic [31:0]               wdata_i,
    output logic [32*LINE_WORDS-1:0]  rdata_o,
    output logic                      resp_o,
    output logic                      err_o,
    output logic                      busy_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [3:0]                wb_sel_o,
    output logic [31:0]               wb_addr_o,
    output logic [31:0]               wb_data_o,
    input  logic [31:0]               wb_data_i,
    input  logic                      wb_ack_i
);

    localparam int c_BEAT_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int c_TMO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int c_LINE_LSB = $clog2(4 * LINE_WORDS);
    localparam int c_RD_W     = 32 * LINE_WORDS;

    localparam logic [1:0] c_W_BYTE = 2'd0;
    localparam logic [1:0] c_W_HALF = 2'd1;
    localparam logic [1:0] c_W_WORD = 2'd2;
    localparam logic [1:0] c_W_LINE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_cmd;
    logic [1:0]             r_width;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [c_BEAT_W-1:0]    r_beat;
    logic [c_TMO_W-1:0]     r_tmo;
    logic                   r_err;
    logic [c_RD_W-1:0]      r_buf;
    logic [c_RD_W-1:0]      r_rdata;

    logic                   w_ack;
    logic [31:0]            w_dat;
    logic                   w_mis;
    logic                   w_last;
    logic                   w_tmo;
    logic [3:0]             w_sel;
    logic [31:0]            w_wdata;
    logic [c_RD_W-1:0]      w_line;
    logic [c_RD_W-1:0]      w_rd_ext;

    // Only acks seen while waiting are registered, so a stray ack never
    // leaks into a later WAIT through the delayed copy.
    generate
        if (REG_RESP != 0) begin : g_reg_resp
            logic        r_ack_q;
            logic [31:0] r_dat_q;
            always_ff @(posedge sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ack_q <= 1'b0;
                    r_dat_q <= 32'd0;
                end else begin
                    r_ack_q <= wb_ack_i && (r_state == S_WAIT);
                    r_dat_q <= wb_data_i;
                end
            end
            assign w_ack = r_ack_q;
            assign w_dat = r_dat_q;
        end else begin : g_raw_resp
            assign w_ack = wb_ack_i;
            assign w_dat = wb_data_i;
        end
    endgenerate

    assign w_last = (r_width != c_W_LINE) || (r_beat == c_BEAT_W'(LINE_WORDS - 1));
    assign w_tmo  = (TIMEOUT_CYCLES != 0) && (r_tmo == c_TMO_W'(TIMEOUT_CYCLES));

    always_comb begin
        w_mis   = 1'b0;
        w_sel   = 4'b1111;
        w_wdata = r_wdata;
        unique case (r_width)
            c_W_BYTE: begin
                w_sel   = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            c_W_HALF: begin
                w_mis   = r_addr[0];
                w_sel   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            c_W_WORD: w_mis = |r_addr[1:0];
            c_W_LINE: w_mis = (|r_addr[c_LINE_LSB-1:0]) || r_cmd;
        endcase
    end

    // Final read result: the beat being acked merged over the line buffer.
    always_comb begin
        w_line                           = r_buf;
        w_line[32*int'(r_beat) +: 32]    = w_dat;
        w_rd_ext                         = '0;
        unique case (r_width)
            c_W_BYTE: w_rd_ext[7:0]  = w_dat[8*int'(r_addr[1:0]) +: 8];
            c_W_HALF: w_rd_ext[15:0] = w_dat[16*int'(r_addr[1]) +: 16];
            c_W_WORD: w_rd_ext[31:0] = w_dat;
            c_W_LINE: w_rd_ext       = w_line;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_i) w_next = S_CHECK;
            S_CHECK: w_next = w_mis ? S_DONE : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_ack)      w_next = w_last ? S_DONE : S_ISSUE;
                else if (w_tmo) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cmd   <= 1'b0;
            r_width <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_beat  <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
            r_buf   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_cmd   <= cmd_i;
                        r_width <= width_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_beat  <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_mis) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                S_ISSUE: r_tmo <= '0;
                S_WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (w_ack) begin
                        r_buf[32*int'(r_beat) +: 32] <= w_dat;
                        if (!w_last)
                            r_beat <= r_beat + 1'b1;
                        else if (!r_cmd)
                            r_rdata <= w_rd_ext;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (r_state != S_IDLE);
    assign resp_o    = (r_state == S_DONE);
    assign err_o     = resp_o && r_err;
    assign rdata_o   = r_rdata;
    assign wb_cyc_o  = (r_state == S_ISSUE) || ((r_state == S_WAIT) && (w_ack || !w_tmo));
    assign wb_stb_o  = (r_state == S_ISSUE);
    assign wb_we_o   = wb_cyc_o && r_cmd;
    assign wb_sel_o  = wb_cyc_o ? w_sel : 4'd0;
    assign wb_addr_o = wb_cyc_o ? ({r_addr[31:2], 2'b00} + (32'(r_beat) << 2)) : 32'd0;
    assign wb_data_o = (wb_cyc_o && r_cmd) ? w_wdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_core_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_core_wb_bridge
// Brief  : Scoreboard bench for core_wb_bridge (LINE_WORDS=4, REG_RESP=1,
//          TIMEOUT_CYCLES=8) with a Wishbone slave model.
// Rev    : 1.0  initial release
// ============================================================================

module tb_core_wb_bridge;

    localparam int GAP = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          cmd = 1'b0;
    logic [1:0]    width = 2'd0;
    logic [31:0]   addr = 32'd0;
    logic [31:0]   wdata = 32'd0;
    logic [31:0]   wb_data_i = 32'd0;
    logic          wb_ack_i = 1'b0;
    logic [127:0]  rdata_o;
    logic          resp_o, err_o, busy_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [31:0]   wb_addr_o, wb_data_o;

    core_wb_bridge #(
        .LINE_WORDS(4), .REG_RESP(1), .TIMEOUT_CYCLES(8)
    ) dut (
        .sys_clk(clk), .rst_n(rst_n), .req_i(req), .cmd_i(cmd), .width_i(width),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_o), .resp_o(resp_o),
        .err_o(err_o), .busy_o(busy_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic         err;
        logic [127:0] rdata;
        logic         chk_rd;
        int           lat;
        int           n_req;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
    } bus_t;

    resp_t sbq[$];
    bus_t  busq[$];
    int    checks = 0;
    int    errors = 0;
    int    resp_cnt = 0;
    int    stb_cnt = 0;
    logic  mute = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5A5A5);
    endfunction

    task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] sel,
                            input logic [31:0] d);
        bus_t b;
        b.addr = a; b.we = we; b.sel = sel; b.data = d;
        busq.push_back(b);
    endtask

    // Response monitor
    initial begin : mon
        resp_t e;
        forever begin
            @(negedge clk);
            if (resp_o === 1'b1) begin
                resp_cnt++;
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got resp_o=1, expected none");
                end else begin
                    e = sbq.pop_front();
                    chk("resp_err", err_o, e.err);
                    if (e.chk_rd) chk("rdata", rdata_o, e.rdata);
                    if (e.lat > 0) chk("resp_latency", cyc_n - e.n_req + 1, e.lat);
                end
            end
        end
    end

    // Wishbone slave model: checks each strobe, acks GAP cycles after it
    initial begin : slv
        bus_t        b;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (wb_cyc_o && wb_stb_o) begin
                stb_cnt++;
                a = wb_addr_o;
                if (busq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_stb: got stb at %h, expected none", a);
                end else begin
                    b = busq.pop_front();
                    chk("stb_addr", wb_addr_o, b.addr);
                    chk("stb_we", wb_we_o, b.we);
                    if (b.we) begin
                        chk("stb_sel", wb_sel_o, b.sel);
                        chk("stb_wdata", wb_data_o, b.data);
                    end
                end
                if (!mute) begin
                    @(posedge clk);
                    repeat (GAP) @(posedge clk);
                    #1 wb_ack_i = 1'b1; wb_data_i = slave_rd(a);
                    @(posedge clk);
                    #1 wb_ack_i = 1'b0; wb_data_i = 32'd0;
                end
            end
        end
    end

    task automatic do_req(input logic c, input logic [1:0] w, input logic [31:0] a,
                          input logic [31:0] d, output int n);
        int k = 0;
        @(negedge clk);
        while (busy_o && k < 60) begin @(negedge clk); k++; end
        if (busy_o) begin
            checks++; errors++;
            $display("FAIL idle_wait: got busy_o=1, expected 0 within 60 cycles");
        end
        req = 1'b1; cmd = c; width = w; addr = a; wdata = d;
        @(posedge clk);
        #1 n = cyc_n; req = 1'b0;
    endtask

    // mode 1: no bus cycle allowed; mode 2: cyc must stay high until DONE
    task automatic run_op(input logic c, input logic [1:0] w, input logic [31:0] a,
                          input logic [31:0] d, input logic e_err, input logic [127:0] e_rd,
                          input logic chk_rd, input int lat, input int mode);
        int    n;
        int    k = 0;
        logic  saw = 1'b0;
        logic  gap = 1'b0;
        resp_t r;
        do_req(c, w, a, d, n);
        r.err = e_err; r.rdata = e_rd; r.chk_rd = chk_rd; r.lat = lat; r.n_req = n;
        sbq.push_back(r);
        do begin
            @(negedge clk); k++;
            if (wb_cyc_o) saw = 1'b1;
            else if (saw && !resp_o) gap = 1'b1;
        end while (!resp_o && k < 60);
        if (!resp_o) begin
            checks++; errors++;
            $display("FAIL resp_wait: got no resp_o within 60 cycles, expected resp_o");
        end
        if (mode == 1) chk("no_bus_activity", saw, 1'b0);
        if (mode == 2) chk("cyc_continuous", gap, 1'b0);
    endtask

    initial begin : stim
        int n, base, rc, k;
        repeat (2) @(negedge clk);
        chk("reset_rdata", rdata_o, 128'd0);
        chk("reset_ctl", {resp_o, err_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o}, 6'd0);
        chk("reset_bus", {wb_sel_o, wb_addr_o, wb_data_o}, 68'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // reads: word, byte lane 1, upper half
        push_bus(32'h100, 1'b0, 4'd0, 32'd0);
        run_op(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, 128'hDEADBEEF, 1'b1, 6, 0);
        push_bus(32'h100, 1'b0, 4'd0, 32'd0);
        run_op(1'b0, 2'd0, 32'h101, 32'd0, 1'b0, 128'hBE, 1'b1, 6, 0);
        push_bus(32'h100, 1'b0, 4'd0, 32'd0);
        run_op(1'b0, 2'd1, 32'h102, 32'd0, 1'b0, 128'hDEAD, 1'b1, 6, 0);

        // line fetch
        for (int i = 0; i < 4; i++) push_bus(32'h40 + 32'(4 * i), 1'b0, 4'd0, 32'd0);
        run_op(1'b0, 2'd3, 32'h40, 32'd0, 1'b0,
               {32'hA5A5A5E9, 32'hA5A5A5ED, 32'hA5A5A5E1, 32'hA5A5A5E5}, 1'b1, 18, 2);

        // writes
        push_bus(32'h200, 1'b1, 4'b1000, 32'h5A5A5A5A);
        run_op(1'b1, 2'd0, 32'h203, 32'h0000005A, 1'b0, 128'd0, 1'b0, 6, 0);
        push_bus(32'h200, 1'b1, 4'b1100, 32'h12341234);
        run_op(1'b1, 2'd1, 32'h202, 32'h00001234, 1'b0, 128'd0, 1'b0, 6, 0);
        push_bus(32'h300, 1'b1, 4'b1111, 32'hCAFEF00D);
        run_op(1'b1, 2'd2, 32'h300, 32'hCAFEF00D, 1'b0, 128'd0, 1'b0, 6, 0);

        // errors without bus activity
        run_op(1'b0, 2'd2, 32'h102, 32'd0, 1'b1, 128'd0, 1'b1, 2, 1);
        run_op(1'b0, 2'd1, 32'h201, 32'd0, 1'b1, 128'd0, 1'b1, 2, 1);
        run_op(1'b0, 2'd3, 32'h48,  32'd0, 1'b1, 128'd0, 1'b1, 2, 1);
        run_op(1'b1, 2'd3, 32'h40,  32'd0, 1'b1, 128'd0, 1'b1, 2, 1);

        // refill rdata, then timeout must clear it
        push_bus(32'h100, 1'b0, 4'd0, 32'd0);
        run_op(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, 128'hDEADBEEF, 1'b1, 6, 0);
        mute = 1'b1;
        push_bus(32'h80, 1'b0, 4'd0, 32'd0);
        run_op(1'b0, 2'd2, 32'h80, 32'd0, 1'b1, 128'd0, 1'b1, 0, 0);
        mute = 1'b0;
        push_bus(32'h80, 1'b0, 4'd0, 32'd0);
        run_op(1'b0, 2'd2, 32'h80, 32'd0, 1'b0, 128'hA5A5A525, 1'b1, 6, 0);

        // reset during WAIT of the second line beat
        for (int i = 0; i < 4; i++) push_bus(32'h40 + 32'(4 * i), 1'b0, 4'd0, 32'd0);
        base = stb_cnt;
        do_req(1'b0, 2'd3, 32'h40, 32'd0, n);
        k = 0;
        while (stb_cnt < base + 2 && k < 60) begin @(negedge clk); k++; end
        chk("second_beat_seen", stb_cnt - base, 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_async_drop", {wb_cyc_o, wb_stb_o, busy_o}, 3'd0);
        busq.delete();
        rc = resp_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_resp_after_reset", resp_cnt, rc);
        chk("rdata_after_reset", rdata_o, 128'd0);

        // stray ack in IDLE
        @(posedge clk); #1 wb_ack_i = 1'b1; wb_data_i = 32'h12345678;
        repeat (2) @(posedge clk);
        #1 wb_ack_i = 1'b0; wb_data_i = 32'd0;
        repeat (3) @(negedge clk);
        chk("stray_ack_idle", {busy_o, wb_cyc_o}, 2'd0);
        chk("stray_ack_rdata", rdata_o, 128'd0);
        chk("stray_ack_no_resp", resp_cnt, rc);
        push_bus(32'h100, 1'b0, 4'd0, 32'd0);
        run_op(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, 128'hDEADBEEF, 1'b1, 6, 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1);
    end

endmodule

`default_nettype wire
